// File: rtl/stage6_ti4_serializer_pkg.sv
// Shared widths, FSM state encoding and lane helper for the stage-6 TI4 serializer.
package stage6_ti4_serializer_pkg;

  localparam int FIELD_TI4_BITS = 32;
  localparam int DEFAUT_INFOR   = 0;
  localparam int TI4_LANE_W     = 2;
  localparam int TI4_FIFO_DEPTH = 4;

  typedef enum logic {
    S6_IDLE = 1'b0,
    S6_EMIT = 1'b1
  } s6_state_e;

  // Zero-based index of the lowest set lane; an empty mask never reaches here.
  function automatic logic [TI4_LANE_W-1:0] lowest_lane(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

endpackage

// File: rtl/stage6_ti4_serializer_fifo.sv
// Beat FIFO: stores {TI4_1, TI4_2, TI4_3, mask}; exposes head and the entry behind it.
module ti4_beat_fifo #(
  parameter int W     = 99,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [W-1:0]  head_next_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign do_push     = push_i & ~full_o;
  assign do_pop      = pop_i & ~empty_o;
  assign rd_ptr_nxt  = rd_ptr_q + PTR_ONE;
  assign head_o      = mem[rd_ptr_q];
  assign head_next_o = mem[rd_ptr_nxt];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_nxt : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/stage6_ti4_serializer.sv
// Buffers three-lane TI4 beats and emits the non-default fields one per handshake, tagged by lane.
module stage6_ti4_serializer
  import stage6_ti4_serializer_pkg::*;
#(
  parameter int                 TI4_W       = FIELD_TI4_BITS,
  parameter logic [TI4_W-1:0]   DEFAULT_VAL = TI4_W'(DEFAUT_INFOR),
  parameter int                 DEPTH       = TI4_FIFO_DEPTH,
  parameter int                 CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TI4_W-1:0]      TI4_1,
  input  logic [TI4_W-1:0]      TI4_2,
  input  logic [TI4_W-1:0]      TI4_3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TI4_W-1:0]      out_data,
  output logic [TI4_LANE_W-1:0] out_lane,
  output logic                  out_last,
  output logic [CNT_W-1:0]      beat_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int EW = 3 * TI4_W + 3;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [TI4_W-1:0] in_field   [3];
  logic [TI4_W-1:0] head_field [3];
  logic [2:0]       in_mask;
  logic [EW-1:0]    head, head_next;
  logic [CW-1:0]    count;
  logic             full, empty;
  logic [2:0]       head_mask, next_mask, lane_le, higher;
  logic             accept, push, pop, emit, fire, cur_last;

  s6_state_e             state_q, state_d;
  logic [TI4_LANE_W-1:0] lane_q, lane_d;
  logic [CNT_W-1:0]      beat_cnt_q, drop_cnt_q;

  assign in_field[0] = TI4_1;
  assign in_field[1] = TI4_2;
  assign in_field[2] = TI4_3;

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    assign in_mask[gi]    = (in_field[gi] != DEFAULT_VAL);
    assign head_field[gi] = head[3 + (2 - gi) * TI4_W +: TI4_W];
  end

  ti4_beat_fifo #(.W(EW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .din_i       ({TI4_1, TI4_2, TI4_3, in_mask}),
    .pop_i       (pop),
    .head_o      (head),
    .head_next_o (head_next),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign in_ready  = ~full;
  assign accept    = in_valid & in_ready;
  assign push      = accept & (|in_mask);
  assign head_mask = head[2:0];
  assign next_mask = head_next[2:0];
  assign emit      = (state_q == S6_EMIT);
  // lane_le covers lane_q and everything below it; what remains are lanes still to emit.
  assign lane_le   = (3'd2 << lane_q) - 3'd1;
  assign higher    = head_mask & ~lane_le;
  assign cur_last  = (higher == 3'd0);
  assign fire      = emit & out_ready;
  assign pop       = fire & cur_last;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      S6_IDLE: begin
        if (!empty) begin
          state_d = S6_EMIT;
          lane_d  = lowest_lane(head_mask);
        end else if (push) begin
          // Enter EMIT on the push edge so the beat shows one cycle after acceptance.
          state_d = S6_EMIT;
          lane_d  = lowest_lane(in_mask);
        end
      end
      S6_EMIT: begin
        if (fire) begin
          if (!cur_last) begin
            lane_d = lowest_lane(higher);
          end else if (count > CW'(1)) begin
            lane_d = lowest_lane(next_mask);
          end else if (push) begin
            lane_d = lowest_lane(in_mask);
          end else begin
            state_d = S6_IDLE;
          end
        end
      end
      default: state_d = S6_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S6_IDLE;
      lane_q     <= '0;
      beat_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (push && (beat_cnt_q != '1)) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      if (accept && !(|in_mask) && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = emit;
  assign out_data  = emit ? head_field[lane_q] : '0;
  assign out_lane  = emit ? lane_q + 2'd1 : 2'd0;
  assign out_last  = emit & cur_last;
  assign beat_cnt  = beat_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stage6_ti4_serializer.sv
// Directed bench with a queue-based field model checked every cycle, plus literal spot checks.
module tb_stage6_ti4_serializer;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  lane;
    logic        last;
  } fld_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] ti4_1 = '0, ti4_2 = '0, ti4_3 = '0;
  logic        in_ready, out_valid, out_last;
  logic [31:0] out_data;
  logic [1:0]  out_lane;
  logic [15:0] beat_cnt, drop_cnt;

  logic        in_valid2 = 1'b0;
  logic [31:0] s_1 = 32'h1, s_2 = '0, s_3 = '0;
  logic        in_ready2, out_valid2, out_last2;
  logic [31:0] out_data2;
  logic [1:0]  out_lane2;
  logic [3:0]  beat_cnt2, drop_cnt2;

  int   checks = 0;
  int   errors = 0;
  fld_t exp_q[$];
  fld_t log_q[$];
  int   model_beats = 0;
  int   exp_beat = 0;
  int   exp_drop = 0;
  bit   prev_stall = 0;
  fld_t prev_out;
  bit   rand_mode = 0;

  always #5 clk = ~clk;

  stage6_ti4_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .TI4_1(ti4_1), .TI4_2(ti4_2), .TI4_3(ti4_3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .beat_cnt(beat_cnt), .drop_cnt(drop_cnt)
  );

  stage6_ti4_serializer #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .TI4_1(s_1), .TI4_2(s_2), .TI4_3(s_3),
    .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
    .out_lane(out_lane2), .out_last(out_last2), .beat_cnt(beat_cnt2), .drop_cnt(drop_cnt2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: a beat expands into its non-default lanes, lowest first; the highest is last.
  task automatic model_accept(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] v [3];
    int hi;
    v[0] = a; v[1] = b; v[2] = c;
    hi = -1;
    for (int k = 0; k < 3; k++) if (v[k] != 0) hi = k;
    if (hi < 0) begin
      if (exp_drop < 65535) exp_drop++;
    end else begin
      for (int k = 0; k < 3; k++)
        if (v[k] != 0) exp_q.push_back('{data: v[k], lane: 2'(k + 1), last: (k == hi)});
      model_beats++;
      if (exp_beat < 65535) exp_beat++;
    end
  endtask

  always @(negedge clk) begin
    fld_t cur;
    cur = '{data: out_data, lane: out_lane, last: out_last};
    if (rst) begin
      exp_q.delete();
      model_beats = 0;
      exp_beat = 0;
      exp_drop = 0;
      prev_stall = 0;
    end else begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(model_beats < 4));
      check("beat_cnt", 64'(beat_cnt), 64'(exp_beat));
      check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      if (prev_stall) check("stall_hold", 64'(cur), 64'(prev_out));
      if (out_valid && exp_q.size() != 0) check("out_field", 64'(cur), 64'(exp_q[0]));
      if (!out_valid) check("idle_zero", 64'(cur), 64'(0));
      if (out_valid && out_ready) begin
        log_q.push_back(cur);
        if (exp_q.size() != 0) begin
          if (exp_q[0].last) model_beats--;
          void'(exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = cur;
      if (in_valid && in_ready) model_accept(ti4_1, ti4_2, ti4_3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    bit done;
    done = 0;
    in_valid = 1'b1; ti4_1 = a; ti4_2 = b; ti4_3 = c;
    for (int i = 0; i < 300 && !done; i++) begin
      if (in_ready) done = 1;
      tick();
    end
    if (!done) check("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) check("drain_timeout", 64'(0), 64'(1));
    tick();
  endtask

  initial begin
    int n;
    fld_t f;
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_beat_cnt", 64'(beat_cnt), 64'(0));
    rst = 1'b0;
    tick();

    // Single full beat
    out_ready = 1'b1;
    log_q.delete();
    send_beat(32'h11, 32'h22, 32'h33);
    drain();
    check("t1_nfields", 64'(log_q.size()), 64'(3));
    if (log_q.size() == 3) begin
      check("t1_f0", 64'(log_q[0]), 64'({32'h11, 2'd1, 1'b0}));
      check("t1_f1", 64'(log_q[1]), 64'({32'h22, 2'd2, 1'b0}));
      check("t1_f2", 64'(log_q[2]), 64'({32'h33, 2'd3, 1'b1}));
    end
    check("t1_beat_cnt", 64'(beat_cnt), 64'(1));

    // Sparse mask, then an all-default beat
    log_q.delete();
    send_beat(32'h0, 32'hAB, 32'h0);
    send_beat(32'h0, 32'h0, 32'h0);
    drain();
    check("t2_nfields", 64'(log_q.size()), 64'(1));
    if (log_q.size() == 1) check("t2_f0", 64'(log_q[0]), 64'({32'hAB, 2'd2, 1'b1}));
    check("t2_drop_cnt", 64'(drop_cnt), 64'(1));
    check("t2_beat_cnt", 64'(beat_cnt), 64'(2));

    // Back-pressure: four beats fill the FIFO, the fifth is held
    out_ready = 1'b0;
    log_q.delete();
    for (int b = 1; b <= 4; b++)
      send_beat(32'h100 * b + 1, 32'h100 * b + 2, 32'h100 * b + 3);
    in_valid = 1'b1; ti4_1 = 32'h501; ti4_2 = 32'h502; ti4_3 = 32'h503;
    tick(); tick(); tick();
    check("bp_full_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("bp_release_cycles", 64'(n), 64'(3));
    tick();
    in_valid = 1'b0;
    drain();
    check("bp_nfields", 64'(log_q.size()), 64'(15));
    if (log_q.size() == 15) begin
      check("bp_first", 64'(log_q[0]), 64'({32'h101, 2'd1, 1'b0}));
      check("bp_last", 64'(log_q[14]), 64'({32'h503, 2'd3, 1'b1}));
    end

    // Random stalls over 100 beats with sparse lanes
    rand_mode = 1;
    for (int b = 0; b < 100; b++) begin
      logic [31:0] v [3];
      for (int k = 0; k < 3; k++)
        v[k] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      send_beat(v[0], v[1], v[2]);
    end
    rand_mode = 0;
    out_ready = 1'b1;
    drain();

    // Reset with three beats buffered
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) send_beat(32'hA0 + b, 32'h0, 32'hB0 + b);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_beat_cnt", 64'(beat_cnt), 64'(0));
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    log_q.delete();
    send_beat(32'h0, 32'h0, 32'h5A);
    drain();
    check("post_rst_nfields", 64'(log_q.size()), 64'(1));
    if (log_q.size() == 1) check("post_rst_f0", 64'(log_q[0]), 64'({32'h5A, 2'd3, 1'b1}));

    // Saturation on the 4-bit counter instance
    in_valid2 = 1'b1;
    n = 0;
    for (int i = 0; i < 500 && n < 20; i++) begin
      if (in_ready2) n++;
      tick();
    end
    in_valid2 = 1'b0;
    tick();
    check("sat_accepts", 64'(n), 64'(20));
    check("sat_beat_cnt", 64'(beat_cnt2), 64'(15));
    check("sat_drop_cnt", 64'(drop_cnt2), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
